// File: rtl/sha256_result_tx.sv
// Result return path: buffers SHA-256 digests and replays each one as a byte-wide AXI-stream frame.
// Optional SHA256_TX_LEN_HDR_EN prepends an 8-byte big-endian message-length header to every frame.
module sha256_result_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         ivalid,
  input  logic [31:0]                  iid,
  input  logic [60:0]                  ilen,
  input  logic [255:0]                 isha,
  output logic                         tvalid,
  input  logic                         tready,
  output logic                         tlast,
  output logic [31:0]                  tid,
  output logic [7:0]                   tdata,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  output logic                         overflow,
  output logic [15:0]                  drop_cnt
);

`ifdef SHA256_TX_LEN_HDR_EN
  localparam int FRAME_LEN = 40;
`else
  localparam int FRAME_LEN = 32;
`endif
  localparam int SRW = FRAME_LEN * 8;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int BW  = $clog2(FRAME_LEN);
  localparam int EW  = 32 + 61 + 256;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST_B  = BW'(FRAME_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_n;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [SRW-1:0]  sr;
  logic [31:0]     id_q;
  logic [BW-1:0]   bcnt;
  logic            pop, push, drop, accept, last_byte;
  logic [EW-1:0]   head;
  logic [31:0]     head_id;
  logic [60:0]     head_len;
  logic [255:0]    head_sha;
  logic [SRW-1:0]  load_val;

  assign head     = mem[rd_ptr];
  assign head_id  = head[348:317];
  assign head_len = head[316:256];
  assign head_sha = head[255:0];

`ifdef SHA256_TX_LEN_HDR_EN
  assign load_val = {3'b000, head_len, head_sha};
`else
  logic unused_len;
  assign unused_len = ^head_len;
  assign load_val   = head_sha;
`endif

  assign accept    = (state == SEND) && tready;
  assign last_byte = (state == SEND) && (bcnt == LAST_B);
  // A pop frees a slot in the same cycle, so a push at full is only dropped without one.
  assign push      = ivalid && ((level != DEPTH_L) || pop);
  assign drop      = ivalid && !push;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop     = 1'b1;
          state_n = SEND;
        end
      end
      SEND: begin
        if (accept && last_byte) begin
          if (level != '0) pop = 1'b1;
          else             state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: the storage array has no reset; validity is tracked by level and the pointers alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {iid, ilen, isha};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      sr       <= '0;
      id_q     <= '0;
      bcnt     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      if (pop) begin
        sr   <= load_val;
        id_q <= head_id;
        bcnt <= '0;
      end else if (accept) begin
        sr   <= {sr[SRW-9:0], 8'h00};
        bcnt <= last_byte ? '0 : bcnt + BW'(1);
      end
    end
  end

  assign tvalid = (state == SEND);
  assign tdata  = tvalid ? sr[SRW-1 -: 8] : 8'h00;
  assign tlast  = last_byte;
  assign tid    = (tvalid && bcnt == '0) ? id_q : 32'h0;

endmodule
